// File: rtl/uart_result_tx_if.sv
// Handshake and data bundle between the result-matrix source and the UART result transmitter.
// The source owns the request side (master); the transmitter owns the serial line and status (slave).
interface uart_result_tx_if #(
    parameter int RESULT_W = 512
);
    logic                i_en;
    logic                i_start;
    logic [RESULT_W-1:0] i_result;
    logic                o_tx;
    logic                o_busy;
    logic                o_done;

    modport master (
        output i_en,
        output i_start,
        output i_result,
        input  o_tx,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_en,
        input  i_start,
        input  i_result,
        output o_tx,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/uart_result_tx.sv
// Snapshots the 4x4 result matrix and sends it MSB-byte-first per word as 8N1 frames on the i_en timebase.
// Optional build macro UART_TX_CHECKSUM_EN appends one XOR-checksum frame after the payload.
module uart_result_tx #(
    parameter int N_DATA_BITS = 8,
    parameter int OVERSAMPLE  = 13,
    parameter int N_WORDS     = 16,
    parameter int WORD_BYTES  = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    uart_result_tx_if.slave  io_bus
);
    localparam int N_BYTES = N_WORDS * WORD_BYTES;
    localparam int RES_W   = N_BYTES * 8;
    localparam int TICK_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W   = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;
    localparam int IDX_W   = $clog2(N_BYTES + 1);
`ifdef UART_TX_CHECKSUM_EN
    localparam int LAST_IDX = N_BYTES;
`else
    localparam int LAST_IDX = N_BYTES - 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t                 r_state, w_state;
    logic [TICK_W-1:0]      r_tick,  w_tick;
    logic [BIT_W-1:0]       r_bit,   w_bit;
    logic [IDX_W-1:0]       r_idx,   w_idx;
    logic [RES_W-1:0]       r_snap,  w_snap;
    logic [N_DATA_BITS-1:0] w_cur_byte;
    logic                   w_tick_end;
`ifdef UART_TX_CHECKSUM_EN
    logic [N_DATA_BITS-1:0] r_csum,  w_csum;
`endif

    assign w_tick_end = io_bus.i_en && (r_tick == TICK_W'(OVERSAMPLE - 1));

    // The snapshot shifts left one byte per frame, so the byte on air is always its top byte.
`ifdef UART_TX_CHECKSUM_EN
    assign w_cur_byte = (r_idx == IDX_W'(N_BYTES)) ? r_csum : r_snap[RES_W-1 -: N_DATA_BITS];
`else
    assign w_cur_byte = r_snap[RES_W-1 -: N_DATA_BITS];
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
`ifdef UART_TX_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_bit   <= w_bit;
            r_idx   <= w_idx;
            r_snap  <= w_snap;
`ifdef UART_TX_CHECKSUM_EN
            r_csum  <= w_csum;
`endif
        end
    end

    always_comb begin
        w_state       = r_state;
        w_tick        = r_tick;
        w_bit         = r_bit;
        w_idx         = r_idx;
        w_snap        = r_snap;
`ifdef UART_TX_CHECKSUM_EN
        w_csum        = r_csum;
`endif
        io_bus.o_tx   = 1'b1;
        io_bus.o_busy = 1'b1;
        io_bus.o_done = 1'b0;

        if ((r_state == S_START || r_state == S_DATA || r_state == S_STOP) && io_bus.i_en) begin
            w_tick = w_tick_end ? '0 : r_tick + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                io_bus.o_busy = 1'b0;
                if (io_bus.i_start) begin
                    w_snap  = io_bus.i_result;
                    w_idx   = '0;
                    w_tick  = '0;
                    w_bit   = '0;
`ifdef UART_TX_CHECKSUM_EN
                    w_csum  = '0;
`endif
                    w_state = S_START;
                end
            end
            S_START: begin
                io_bus.o_tx = 1'b0;
                if (w_tick_end) begin
                    w_bit   = '0;
                    w_state = S_DATA;
                end
            end
            S_DATA: begin
                io_bus.o_tx = w_cur_byte[r_bit];
                if (w_tick_end) begin
                    if (r_bit == BIT_W'(N_DATA_BITS - 1)) begin
`ifdef UART_TX_CHECKSUM_EN
                        if (r_idx != IDX_W'(N_BYTES)) begin
                            w_csum = r_csum ^ w_cur_byte;
                        end
`endif
                        w_state = S_STOP;
                    end else begin
                        w_bit = r_bit + 1'b1;
                    end
                end
            end
            S_STOP: begin
                io_bus.o_tx = 1'b1;
                // Back-to-back frames: the next start bit begins on the very next tick.
                if (w_tick_end) begin
                    if (r_idx == IDX_W'(LAST_IDX)) begin
                        w_state = S_DONE;
                    end else begin
                        w_idx   = r_idx + 1'b1;
                        w_snap  = {r_snap[RES_W-N_DATA_BITS-1:0], {N_DATA_BITS{1'b0}}};
                        w_state = S_START;
                    end
                end
            end
            S_DONE: begin
                io_bus.o_busy = 1'b0;
                io_bus.o_done = 1'b1;
                w_state       = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx: decodes the serial stream tick by tick and checks bytes, framing,
// bit widths, o_busy/o_done timing, reset abort, mid-send restart attempts and i_en stalls.
module tb_uart_result_tx;
    localparam int OS  = 13;
    localparam int NB  = 64;
`ifdef UART_TX_CHECKSUM_EN
    localparam int NF  = 65;
`else
    localparam int NF  = 64;
`endif
    localparam int TPF = 10 * OS;

    typedef struct {
        logic [511:0] result;
        int           div;
        int           stall_tick;
        int           restart_tick;
        logic [7:0]   b0;
        logic [7:0]   b3;
        logic [7:0]   b7;
        logic [7:0]   b63;
        logic [7:0]   csum;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_result_tx_if #(.RESULT_W(512)) bus ();

    uart_result_tx dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .io_bus    (bus.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic tick_val [0:NF*TPF-1];
    vec_t vecs [0:5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_xfer(input vec_t v, input int vi);
        logic [7:0] exp_b [0:64];
        logic [7:0] got_b [0:64];
        logic [7:0] x;
        logic [7:0] byte_v;
        int   ntick, cyc, done_c, busy_bad, budget, exp_done;
        logic stalled, held, frozen_ok, framing_ok, bv;

        x = 8'h00;
        for (int k = 0; k < NB; k++) begin
            exp_b[k] = v.result[511 - 8*k -: 8];
            x        = x ^ exp_b[k];
        end
        exp_b[64] = x;

        bus.i_result = v.result;
        bus.i_start  = 1'b1;
        bus.i_en     = 1'b0;
        step();
        bus.i_start  = 1'b0;
        check($sformatf("v%0d accept_busy", vi), 64'(bus.o_busy), 64'd1);
        check($sformatf("v%0d accept_tx", vi), 64'(bus.o_tx), 64'd0);

        ntick    = 0;
        cyc      = 1;
        done_c   = -1;
        busy_bad = 0;
        stalled  = 1'b0;
        budget   = NF * TPF * v.div + 700;
        exp_done = NF * TPF * v.div + 1 + ((v.stall_tick >= 0) ? 500 : 0);

        while (cyc <= budget) begin
            if (ntick == v.restart_tick) begin
                bus.i_start  = 1'b1;
                bus.i_result = ~v.result;
            end else begin
                bus.i_start  = 1'b0;
            end
            if (!stalled && ntick == v.stall_tick) begin
                stalled   = 1'b1;
                bus.i_en  = 1'b0;
                held      = bus.o_tx;
                frozen_ok = 1'b1;
                repeat (500) begin
                    step();
                    cyc++;
                    if (bus.o_tx !== held || bus.o_done !== 1'b0) frozen_ok = 1'b0;
                end
                check($sformatf("v%0d stall_freeze", vi), 64'(frozen_ok), 64'd1);
            end
            bus.i_en = ((cyc % v.div) == 0);
            if (bus.o_done === 1'b1) begin
                done_c = cyc;
                break;
            end
            if (bus.o_busy !== 1'b1) busy_bad++;
            if (bus.i_en) begin
                if (ntick < NF * TPF) tick_val[ntick] = bus.o_tx;
                ntick++;
            end
            step();
            cyc++;
        end
        bus.i_start = 1'b0;

        check($sformatf("v%0d done_cycle", vi), 64'(done_c), 64'(exp_done));
        check($sformatf("v%0d tick_count", vi), 64'(ntick), 64'(NF * TPF));
        check($sformatf("v%0d busy_during", vi), 64'(busy_bad), 64'd0);
        check($sformatf("v%0d done_busy", vi), 64'(bus.o_busy), 64'd0);
        check($sformatf("v%0d done_tx", vi), 64'(bus.o_tx), 64'd1);
        bus.i_en = 1'b0;
        step();
        check($sformatf("v%0d done_width", vi), 64'(bus.o_done), 64'd0);
        check($sformatf("v%0d idle_busy", vi), 64'(bus.o_busy), 64'd0);

        // Each bit must hold one level for exactly OS ticks; start=0, stop=1, data LSB first.
        for (int f = 0; f < NF; f++) begin
            framing_ok = 1'b1;
            byte_v     = 8'h00;
            for (int b = 0; b < 10; b++) begin
                bv = tick_val[f*TPF + b*OS];
                for (int t = 1; t < OS; t++) begin
                    if (tick_val[f*TPF + b*OS + t] !== bv) framing_ok = 1'b0;
                end
                if (b == 0 && bv !== 1'b0) framing_ok = 1'b0;
                if (b == 9 && bv !== 1'b1) framing_ok = 1'b0;
                if (b >= 1 && b <= 8) byte_v[b-1] = bv;
            end
            got_b[f] = byte_v;
            check($sformatf("v%0d frame%0d_framing", vi, f), 64'(framing_ok), 64'd1);
            check($sformatf("v%0d frame%0d_byte", vi, f), 64'(byte_v), 64'(exp_b[f]));
        end
        check($sformatf("v%0d hand_b0", vi), 64'(got_b[0]), 64'(v.b0));
        check($sformatf("v%0d hand_b3", vi), 64'(got_b[3]), 64'(v.b3));
        check($sformatf("v%0d hand_b7", vi), 64'(got_b[7]), 64'(v.b7));
        check($sformatf("v%0d hand_b63", vi), 64'(got_b[63]), 64'(v.b63));
`ifdef UART_TX_CHECKSUM_EN
        check($sformatf("v%0d hand_csum", vi), 64'(got_b[64]), 64'(v.csum));
`endif
    endtask

    initial begin
        logic [511:0] r;
        int   ntick;
        logic idle_ok;

        // Table of directed transfers with hand-computed key bytes.
        r = '0; r[511:480] = 32'hA5_01_FF_00;
        vecs[0] = '{r, 1, -1, -1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h5B};
        r = '0;
        for (int k = 0; k < 16; k++) r[511 - 32*k -: 32] = 32'(k);
        vecs[1] = '{r, 2, -1, -1, 8'h00, 8'h00, 8'h01, 8'h0F, 8'h00};
        r = {16{32'hDEADBEEF}};
        vecs[2] = '{r, 1, -1, 10*TPF, 8'hDE, 8'hEF, 8'hEF, 8'hEF, 8'h00};
        r = '0; r[31:0] = 32'h0000_0081;
        vecs[3] = '{r, 1, -1, -1, 8'h00, 8'h00, 8'h00, 8'h81, 8'h81};
        r = {16{32'h01020304}};
        vecs[4] = '{r, 1, 2*TPF + 4*OS + 6, -1, 8'h01, 8'h04, 8'h04, 8'h04, 8'h00};
        r = '0; r[511:480] = 32'h0000_0080;
        vecs[5] = '{r, 1, -1, -1, 8'h00, 8'h80, 8'h00, 8'h00, 8'h80};

        bus.i_en     = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_result = '0;

        repeat (3) @(negedge clk);
        check("reset_tx", 64'(bus.o_tx), 64'd1);
        check("reset_busy", 64'(bus.o_busy), 64'd0);
        check("reset_done", 64'(bus.o_done), 64'd0);
        rst_n = 1'b1;
        step();

        // Reset in the middle of byte 5 data bits must abort at once.
        bus.i_result = vecs[0].result;
        bus.i_start  = 1'b1;
        step();
        bus.i_start  = 1'b0;
        bus.i_en     = 1'b1;
        ntick        = 0;
        while (ntick < 5*TPF + 2*OS + 4) begin
            step();
            ntick++;
        end
        check("abort_pre_tx", 64'(bus.o_tx), 64'd0);
        check("abort_pre_busy", 64'(bus.o_busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tx", 64'(bus.o_tx), 64'd1);
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        check("abort_done", 64'(bus.o_done), 64'd0);
        step();
        rst_n   = 1'b1;
        idle_ok = 1'b1;
        repeat (300) begin
            step();
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) idle_ok = 1'b0;
        end
        check("abort_stays_idle", 64'(idle_ok), 64'd1);
        bus.i_en = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i], i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
